choose_judge: RTL and testbench



---
 rtl/choose_judge_if.sv | 22 ++
 rtl/choose_judge.sv | 138 +++++++++++++
 tb/tb_choose_judge.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/choose_judge_if.sv
// Handshake bundle between the game controller / player button and the choose_judge responder.
interface choose_judge_if;
  logic       active;
  logic [3:0] turn;
  logic [2:0] die_a;
  logic [2:0] die_b;
  logic       btn;
  logic       done;
  logic [1:0] result;
  logic [3:0] point;
  logic [3:0] sum;

  modport master (
    output active, turn, die_a, die_b, btn,
    input  done, result, point, sum
  );

  modport slave (
    input  active, turn, die_a, die_b, btn,
    output done, result, point, sum
  );
endinterface

// File: rtl/choose_judge.sv
// Waits for a debounced button press while the controller is in CHOOSE, samples the dice
// and returns a craps-style verdict with a one-cycle done strobe.
module choose_judge #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MAX_TURNS       = 10
) (
  input logic           clk,
  input logic           rst,
  choose_judge_if.slave bus
);

  localparam int unsigned     CntW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] DbLast    = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      TurnLimit = 4'(MAX_TURNS);
  localparam logic [1:0]      ResCont   = 2'b00;
  localparam logic [1:0]      ResLost   = 2'b01;
  localparam logic [1:0]      ResWon    = 2'b10;

  typedef enum logic [1:0] {StIdle, StArmed, StEval, StHold} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_db_level;
  logic            r_db_prev;
  logic [CntW-1:0] r_db_cnt;
  logic            r_done;
  logic [1:0]      r_result;
  logic [3:0]      r_point;
  logic [3:0]      r_sum;

  logic            w_press;
  logic            w_legal;
  logic            w_capture;
  logic [3:0]      w_dice_sum;
  logic [1:0]      w_verdict;
  logic [3:0]      w_point_next;

  // Synchronizer and debouncer: level follows the synced button only after a full mismatch run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_sync1   <= bus.btn;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_level;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DbLast) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CntW'(1);
      end
    end
  end

  assign w_press    = r_db_level & ~r_db_prev;
  assign w_legal    = (bus.die_a != 3'd0) && (bus.die_a != 3'd7) &&
                      (bus.die_b != 3'd0) && (bus.die_b != 3'd7);
  assign w_dice_sum = {1'b0, bus.die_a} + {1'b0, bus.die_b};

  // Turn 0 is judged as a first roll.
  always_comb begin
    w_verdict    = ResCont;
    w_point_next = r_point;
    if (bus.turn <= 4'd1) begin
      if (r_sum == 4'd7 || r_sum == 4'd11) begin
        w_verdict    = ResWon;
        w_point_next = 4'd0;
      end else if (r_sum == 4'd2 || r_sum == 4'd3 || r_sum == 4'd12) begin
        w_verdict    = ResLost;
        w_point_next = 4'd0;
      end else begin
        w_point_next = r_sum;
      end
    end else if (r_sum == r_point) begin
      w_verdict    = ResWon;
      w_point_next = 4'd0;
    end else if (r_sum == 4'd7 || bus.turn >= TurnLimit) begin
      w_verdict    = ResLost;
      w_point_next = 4'd0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.active) w_state_next = StArmed;
      end
      StArmed: begin
        if (!bus.active) begin
          w_state_next = StIdle;
        end else if (w_press && w_legal) begin
          w_capture    = 1'b1;
          w_state_next = StEval;
        end
      end
      // The verdict completes even if active has already dropped; HOLD then returns to IDLE.
      StEval: w_state_next = StHold;
      StHold: begin
        if (!bus.active) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_done   <= 1'b0;
      r_result <= ResCont;
      r_point  <= 4'd0;
      r_sum    <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == StEval);
      if (w_capture) r_sum <= w_dice_sum;
      if (r_state == StEval) begin
        r_result <= w_verdict;
        r_point  <= w_point_next;
      end
    end
  end

  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.point  = r_point;
  assign bus.sum    = r_sum;

endmodule

// File: tb/tb_choose_judge.sv
// Randomized bench for choose_judge against a behavioural game model, plus directed scenarios.
module tb_choose_judge;

  localparam int Db   = 4;
  localparam int MaxT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  choose_judge_if bus_if ();

  choose_judge #(
    .DEBOUNCE_CYCLES(Db),
    .MAX_TURNS      (MaxT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  // Model state: raw button history, synced samples since last level change, game phase.
  bit hist[$];
  bit since[$];
  bit m_level;
  bit m_rose;
  int m_phase;   // 0 waiting for CHOOSE, 1 awaiting roll, 2 judging, 3 result shown
  int m_sum;
  int m_point;
  int m_result;
  bit m_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void judge(input int t, input int s, input int p,
                                output int res, output int np);
    np  = p;
    res = 0;
    if (t <= 1) begin
      if (s == 7 || s == 11) begin res = 2; np = 0; end
      else if (s == 2 || s == 3 || s == 12) begin res = 1; np = 0; end
      else np = s;
    end else if (s == p) begin res = 2; np = 0; end
    else if (s == 7) begin res = 1; np = 0; end
    else if (t >= MaxT) begin res = 1; np = 0; end
  endfunction

  function automatic void model_reset();
    hist.delete();
    since.delete();
    m_level  = 1'b0;
    m_rose   = 1'b0;
    m_phase  = 0;
    m_sum    = 0;
    m_point  = 0;
    m_result = 0;
    m_done   = 1'b0;
  endfunction

  function automatic void model_step();
    bit synced;
    bit press;
    bit all_diff;
    int a, b, r, np;
    a     = int'(bus_if.die_a);
    b     = int'(bus_if.die_b);
    press = m_rose;
    hist.push_front(bus_if.btn);
    if (hist.size() > 3) void'(hist.pop_back());
    synced = (hist.size() == 3) ? hist[2] : 1'b0;
    // Level changes once the last Db synced samples since the previous change all disagree.
    m_rose = 1'b0;
    since.push_back(synced);
    if (since.size() > Db) void'(since.pop_front());
    if (since.size() == Db) begin
      all_diff = 1'b1;
      for (int i = 0; i < Db; i++) if (since[i] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        m_rose  = m_level;
        since.delete();
      end
    end
    m_done = 1'b0;
    case (m_phase)
      0: if (bus_if.active) m_phase = 1;
      1: begin
        if (!bus_if.active) m_phase = 0;
        else if (press && a >= 1 && a <= 6 && b >= 1 && b <= 6) begin
          m_sum   = a + b;
          m_phase = 2;
        end
      end
      2: begin
        judge(int'(bus_if.turn), m_sum, m_point, r, np);
        m_result = r;
        m_point  = np;
        m_done   = 1'b1;
        m_phase  = 3;
      end
      default: if (!bus_if.active) m_phase = 0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      chk("cyc_done", bus_if.done, m_done);
      chk("cyc_result", bus_if.result, m_result);
      chk("cyc_point", bus_if.point, m_point);
      chk("cyc_sum", bus_if.sum, m_sum);
      if (bus_if.done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) begin
        lat = i;
        break;
      end
    end
    #1;
  endtask

  task automatic roll(input int t, input int a, input int b, input int exp_res,
                      input int exp_pt, input string name);
    int lat;
    bus_if.active = 1'b1;
    tick(2);
    bus_if.turn  = 4'(t);
    bus_if.die_a = 3'(a);
    bus_if.die_b = 3'(b);
    bus_if.btn   = 1'b1;
    wait_done(20, lat);
    chk({name, "_seen"}, int'(lat > 0), 1);
    chk({name, "_res"}, bus_if.result, exp_res);
    chk({name, "_pt"}, bus_if.point, exp_pt);
    chk({name, "_model"}, m_result, exp_res);
    bus_if.btn = 1'b0;
    tick(10);
    bus_if.active = 1'b0;
    tick(2);
  endtask

  initial begin
    int lat;
    int cnt;
    bus_if.active = 1'b0;
    bus_if.turn   = 4'd1;
    bus_if.die_a  = 3'd1;
    bus_if.die_b  = 3'd1;
    bus_if.btn    = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_done", bus_if.done, 0);
    chk("reset_result", bus_if.result, 0);
    chk("reset_point", bus_if.point, 0);
    chk("reset_sum", bus_if.sum, 0);

    // Bounce rejection, then a clean hold with measured latency.
    bus_if.active = 1'b1;
    bus_if.die_a  = 3'd3;
    bus_if.die_b  = 3'd4;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      bus_if.btn = ~bus_if.btn;
      tick(1);
    end
    bus_if.btn = 1'b0;
    tick(12);
    chk("bounce_none", done_cnt, 0);
    bus_if.btn = 1'b1;
    wait_done(20, lat);
    chk("press_latency", lat, 8);
    chk("natural_res", bus_if.result, 2);
    chk("natural_pt", bus_if.point, 0);
    tick(6);
    bus_if.btn = 1'b0;
    tick(12);
    chk("one_done", done_cnt, 1);
    bus_if.active = 1'b0;
    tick(2);

    roll(1, 1, 1, 1, 0, "craps");
    chk("craps_sum", bus_if.sum, 2);
    roll(1, 2, 3, 0, 5, "point5");
    roll(2, 1, 4, 2, 0, "point_win");
    roll(1, 2, 4, 0, 6, "point6");
    roll(2, 3, 4, 1, 0, "seven_out");
    roll(1, 4, 4, 0, 8, "point8");
    roll(3, 2, 2, 1, 0, "turn_limit");

    // Illegal die discarded, then a legal roll and a long hold.
    bus_if.active = 1'b1;
    tick(2);
    bus_if.turn  = 4'd1;
    bus_if.die_a = 3'd0;
    bus_if.die_b = 3'd3;
    cnt          = done_cnt;
    bus_if.btn   = 1'b1;
    tick(15);
    chk("illegal_no_done", done_cnt, cnt);
    bus_if.btn = 1'b0;
    tick(10);
    bus_if.die_a = 3'd5;
    bus_if.die_b = 3'd6;
    bus_if.btn   = 1'b1;
    wait_done(20, lat);
    chk("legal_after_illegal", int'(lat > 0), 1);
    chk("legal_res", bus_if.result, 2);
    bus_if.btn = 1'b0;
    cnt        = done_cnt;
    tick(20);
    chk("hold_no_done", done_cnt, cnt);
    chk("hold_res", bus_if.result, 2);
    bus_if.active = 1'b0;
    tick(2);

    // Random rolls with bounce, illegal dice and early active drops.
    for (int g = 0; g < 40; g++) begin
      bus_if.active = 1'b1;
      tick($urandom_range(1, 3));
      bus_if.turn  = 4'($urandom_range(0, 4));
      bus_if.die_a = 3'($urandom_range(0, 7));
      bus_if.die_b = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 4)) begin
        bus_if.btn = 1'($urandom_range(0, 1));
        tick(1);
      end
      bus_if.btn = 1'b1;
      tick($urandom_range(5, 12));
      if ($urandom_range(0, 3) == 0) bus_if.active = 1'b0;
      bus_if.btn = 1'b0;
      tick(10);
      bus_if.active = 1'b0;
      tick(2);
    end

    // Asynchronous reset while judging.
    roll(1, 2, 3, 0, 5, "pre_rst");
    bus_if.active = 1'b1;
    tick(2);
    bus_if.turn  = 4'd2;
    bus_if.die_a = 3'd3;
    bus_if.die_b = 3'd4;
    bus_if.btn   = 1'b1;
    tick(7);
    chk("eval_sum", bus_if.sum, 7);
    rst        = 1'b1;
    bus_if.btn = 1'b0;
    #1;
    chk("rst_done", bus_if.done, 0);
    chk("rst_result", bus_if.result, 0);
    chk("rst_point", bus_if.point, 0);
    chk("rst_sum", bus_if.sum, 0);
    tick(2);
    rst = 1'b0;
    cnt = done_cnt;
    tick(20);
    chk("no_done_after_rst", done_cnt, cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
